// File: rtl/register_access_ctrl.sv
// register_access_ctrl
// Host-facing command initiator for a 16 x 8-bit register unit. It accepts
// single read/write/clear commands over a valid/ready handshake, drives the
// unit's load/addr/data_in strobes from registers, and returns read data over
// a valid/ready response channel, absorbing the unit's one-cycle read latency.
// Optional feature macro: REGCTL_CLEAR_SWEEP_EN enables op 10 (clear sweep).
module register_access_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  err,
    output logic                  reg_load,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [DATA_WIDTH-1:0] reg_data_out
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_WAIT,
        RESP
`ifdef REGCTL_CLEAR_SWEEP_EN
        , CLEAR
`endif
    } state_t;

`ifdef REGCTL_CLEAR_SWEEP_EN
    // Last slot touched by the clear sweep; the sweep stops here, never wraps.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);
`endif

    state_t                state, state_nxt;
    logic                  load_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] din_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
    logic                  err_nxt;

    // Ready only in IDLE, and held low while reset is asserted.
    assign cmd_ready = (state == IDLE) && !reset;

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nxt     = state;
        load_nxt      = 1'b0;
        addr_nxt      = reg_addr;
        din_nxt       = reg_data_in;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        err_nxt       = err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_READ: begin
                            addr_nxt  = cmd_addr;
                            state_nxt = RD_ADDR;
                        end
                        OP_WRITE: begin
                            addr_nxt  = cmd_addr;
                            din_nxt   = cmd_data;
                            load_nxt  = 1'b1;
                            state_nxt = WRITE;
                        end
`ifdef REGCTL_CLEAR_SWEEP_EN
                        OP_CLEAR: begin
                            // Sweep starts at slot 0 regardless of cmd_addr.
                            addr_nxt  = '0;
                            din_nxt   = '0;
                            load_nxt  = 1'b1;
                            state_nxt = CLEAR;
                        end
`endif
                        default: begin
                            // Unsupported op: swallow the command, flag it.
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            WRITE:   state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: begin
                rsp_data_nxt  = reg_data_out;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
`ifdef REGCTL_CLEAR_SWEEP_EN
            CLEAR: begin
                // reg_addr doubles as the sweep counter.
                if (reg_addr == LAST_ADDR) begin
                    state_nxt = IDLE;
                end else begin
                    load_nxt = 1'b1;
                    addr_nxt = reg_addr + ADDR_WIDTH'(1);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset drops everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values computed above.
        if (reset) begin
            state       <= IDLE;
            reg_load    <= 1'b0;
            reg_addr    <= '0;
            reg_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            reg_load    <= load_nxt;
            reg_addr    <= addr_nxt;
            reg_data_in <= din_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_register_access_ctrl.sv
// tb_register_access_ctrl
// Bench for register_access_ctrl: a table of directed commands, hand-written
// reset/clear sequences, then random commands scored against a slot-array
// model. A small behavioural register unit sits on the reg_* side.
module tb_register_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RC = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          err;
    logic          reg_load;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_data_in;
    logic [DW-1:0] reg_data_out;

    int tests = 0;
    int fails = 0;

    // Reference model: slot contents and sticky error flag.
    logic [DW-1:0] mem_model [RC];
    logic          err_model = 1'b0;

    // Behavioural register unit: write on load, registered read of addr.
    logic [DW-1:0] unit_mem [RC];
    always @(posedge clock) begin
        if (reg_load) unit_mem[reg_addr] <= reg_data_in;
        reg_data_out <= unit_mem[reg_addr];
    end

    register_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err(err), .reg_load(reg_load), .reg_addr(reg_addr),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out)
    );

    always #5 clock = ~clock;

`ifdef REGCTL_CLEAR_SWEEP_EN
    localparam logic [DW-1:0] EXP_AFTER_CLEAR = 8'h00;
`else
    localparam logic [DW-1:0] EXP_AFTER_CLEAR = 8'hFF;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for ready, present one command, return #1 after the
    // acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = DW'($urandom);
    endtask

    task automatic write_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue(2'b01, a, d);
        check("wr_load_high", reg_load, 1);
        check("wr_addr", reg_addr, a);
        check("wr_data", reg_data_in, d);
        check("wr_ready_low", cmd_ready, 0);
        tick();
        check("wr_load_drop", reg_load, 0);
        check("wr_ready_back", cmd_ready, 1);
        check("wr_addr_hold", reg_addr, a);
        mem_model[a] = d;
    endtask

    task automatic read_cmd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
        rsp_ready = (hold == 0);
        issue(2'b00, a, DW'($urandom));
        check("rd_no_load", reg_load, 0);
        check("rd_addr", reg_addr, a);
        check("rd_ready_low", cmd_ready, 0);
        check("rd_valid_e0", rsp_valid, 0);
        tick();
        check("rd_valid_e1", rsp_valid, 0);
        tick();
        check("rd_valid_rise", rsp_valid, 1);
        check("rd_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rd_hold_valid", rsp_valid, 1);
            check("rd_hold_data", rsp_data, exp);
            check("rd_hold_ready_low", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("rd_valid_drop", rsp_valid, 0);
        check("rd_ready_back", cmd_ready, 1);
        rsp_ready = 1'b0;
    endtask

    task automatic bad_cmd(input logic [1:0] op, input logic [AW-1:0] a);
        issue(op, a, DW'($urandom));
        check("bad_err_set", err, 1);
        check("bad_no_load", reg_load, 0);
        check("bad_stay_idle", cmd_ready, 1);
        tick();
        check("bad_no_load_later", reg_load, 0);
        err_model = 1'b1;
    endtask

    task automatic clear_cmd();
`ifdef REGCTL_CLEAR_SWEEP_EN
        issue(2'b10, AW'($urandom), DW'($urandom));
        for (int i = 0; i < RC; i++) begin
            check("clr_load", reg_load, 1);
            check("clr_addr", reg_addr, i);
            check("clr_data", reg_data_in, 0);
            check("clr_ready_low", cmd_ready, 0);
            tick();
        end
        check("clr_load_drop", reg_load, 0);
        check("clr_ready_back", cmd_ready, 1);
        for (int i = 0; i < RC; i++) mem_model[i] = '0;
`else
        bad_cmd(2'b10, AW'($urandom));
`endif
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            hold;
        logic [DW-1:0] exp_rsp;
        logic          exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs = '{
            '{2'd1, 4'd3, 8'hA5, 0, 8'h00, 1'b0},
            '{2'd1, 4'd7, 8'h3C, 0, 8'h00, 1'b0},
            '{2'd0, 4'd7, 8'h00, 0, 8'h3C, 1'b0},
            '{2'd0, 4'd7, 8'h00, 5, 8'h3C, 1'b0},
            '{2'd0, 4'd3, 8'h00, 1, 8'hA5, 1'b0},
            '{2'd3, 4'd2, 8'h00, 0, 8'h00, 1'b1},
            '{2'd1, 4'd2, 8'h5A, 0, 8'h00, 1'b1},
            '{2'd0, 4'd2, 8'h00, 0, 8'h5A, 1'b1},
            '{2'd1, 4'd3, 8'hC3, 0, 8'h00, 1'b1},
            '{2'd0, 4'd3, 8'h00, 2, 8'hC3, 1'b1}
        };
        for (int i = 0; i < RC; i++) mem_model[i] = '0;

        // Reset: outputs at reset values while asserted, ready right after.
        #2 reset = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err", err, 0);
        check("rst_reg_load", reg_load, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_data_in", reg_data_in, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_release_ready", cmd_ready, 1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            case (vecs[i].op)
                2'd0:    read_cmd(vecs[i].addr, vecs[i].exp_rsp, vecs[i].hold);
                2'd1:    write_cmd(vecs[i].addr, vecs[i].data);
                2'd2:    clear_cmd();
                default: bad_cmd(vecs[i].op, vecs[i].addr);
            endcase
            check("vec_err", err, vecs[i].exp_err);
        end

        // Fill every slot with 0xFF, clear, read both ends.
        for (int a = 0; a < RC; a++) write_cmd(AW'(a), 8'hFF);
        clear_cmd();
        read_cmd(4'd0, EXP_AFTER_CLEAR, 0);
        read_cmd(4'd15, EXP_AFTER_CLEAR, 0);
        check("clear_err", err, err_model);

        // Reset while in RD_WAIT: response must never appear.
        rsp_ready = 1'b1;
        issue(2'b00, 4'd15, 8'h00);
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_err", err, 0);
        check("midrst_reg_load", reg_load, 0);
        check("midrst_reg_addr", reg_addr, 0);
        check("midrst_reg_data_in", reg_data_in, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        tick();
        check("midrst_rsp_valid_held", rsp_valid, 0);
        reset = 1'b0;
        err_model = 1'b0;
        #1;
        check("midrst_release_ready", cmd_ready, 1);
        check("midrst_release_rsp", rsp_valid, 0);
        rsp_ready = 1'b0;
        read_cmd(4'd15, mem_model[15], 0);

        // Random commands against the slot model.
        for (int n = 0; n < 200; n++) begin
            int            r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            r = int'($urandom_range(0, 19));
            a = AW'($urandom);
            d = DW'($urandom);
            if (r < 8)       read_cmd(a, mem_model[a], int'($urandom_range(0, 3)));
            else if (r < 17) write_cmd(a, d);
            else if (r < 19) bad_cmd(2'b11, a);
            else             clear_cmd();
            check("rand_err", err, err_model);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
